// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multicycle restoring divider for the multdiv unit. One quotient bit is
//   produced per clock, so a full operation takes WIDTH iterations plus one
//   cycle for the sign fix-up. Signed and unsigned operation are selected per
//   request. Divide by zero is flagged on exp. The pipeline stalls while busy
//   is high and captures the results when ready pulses.
//
// Parameters
//   WIDTH      operand/result width (>= 4); also the iteration count
//   CNT_W      iteration counter width; 2**CNT_W must exceed WIDTH
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   request; only accepted while busy is low
//   is_signed  in   1 = two's-complement operands, 0 = unsigned
//   A_in       in   dividend, sampled with start
//   B_in       in   divisor, sampled with start
//   quotient   out  registered quotient
//   remainder  out  registered remainder
//   exp        out  divide-by-zero flag, valid with ready
//   ready      out  one-cycle completion pulse
//   busy       out  high while an operation is running
//
// Configuration macro
//   DIVIDER_EARLY_EXIT_EN  when defined, a request whose divisor or dividend
//                          is zero skips the iterations. The result is then
//                          ready in the cycle after the edge following
//                          acceptance.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exp,
  output logic             ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter value at which the final (fix-up) cycle of RUN happens.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_aRaw;
  logic             r_negQ;
  logic             r_negR;
  logic             r_bZero;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_exp;
  logic             r_ready;
  logic             r_busy;

  logic             w_accept;
  logic [WIDTH-1:0] w_aAbs;
  logic [WIDTH-1:0] w_bAbs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_qBit;
  logic [WIDTH-1:0] w_qFinal;
  logic [WIDTH-1:0] w_rFinal;
  logic [CNT_W-1:0] w_cntInit;

  // A request is accepted whenever no operation is running. This includes
  // the DONE cycle, so back-to-back operations lose no extra cycle.
  assign w_accept = start && (r_state != RUN);

  // Magnitudes of the operands. The MIN_INT bit pattern negates to itself.
  // Read as unsigned, that pattern is the correct magnitude 2**(WIDTH-1).
  assign w_aAbs = (is_signed && A_in[WIDTH-1]) ? (~A_in + WIDTH'(1)) : A_in;
  assign w_bAbs = (is_signed && B_in[WIDTH-1]) ? (~B_in + WIDTH'(1)) : B_in;

  // One restoring step. The shifted partial remainder can reach
  // 2**(WIDTH+1)-1. The subtraction therefore gets one extra bit, so that
  // its top bit is a clean borrow/sign.
  assign w_shift = {r_acc, r_dvd[WIDTH-1]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_qBit  = ~w_trial[WIDTH+1];

  // Sign fix-up. Quotients truncate toward zero, and the remainder follows
  // the dividend's sign.
  assign w_qFinal = r_negQ ? (~r_dvd + WIDTH'(1)) : r_dvd;
  assign w_rFinal = r_negR ? (~r_acc + WIDTH'(1)) : r_acc;

  // With early exit, a trivial operation preloads the counter to the
  // fix-up value. It then spends exactly one cycle in RUN. A zero dividend
  // leaves acc and dvd at zero, so quotient and remainder both come out as
  // zero. A zero divisor is replaced by the divide-by-zero result anyway.
`ifdef DIVIDER_EARLY_EXIT_EN
  assign w_cntInit = ((A_in == '0) || (B_in == '0)) ? LAST : '0;
`else
  assign w_cntInit = '0;
`endif

  // Control FSM and datapath. Every output is registered here. Reset
  // clears everything, so an aborted operation never produces a ready pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_dvd       <= '0;
      r_divisor   <= '0;
      r_aRaw      <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_bZero     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_exp       <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_ready <= 1'b0;
          if (w_accept) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_cnt     <= w_cntInit;
            r_acc     <= '0;
            r_dvd     <= w_aAbs;
            r_divisor <= w_bAbs;
            r_aRaw    <= A_in;
            r_negQ    <= is_signed && (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
            r_negR    <= is_signed && A_in[WIDTH-1];
            r_bZero   <= (B_in == '0);
          end else begin
            r_state <= IDLE;
          end
        end

        RUN: begin
          if (r_cnt == LAST) begin
            // The final cycle applies the sign fix-up and publishes results.
            if (r_bZero) begin
              r_quotient  <= '1;
              r_remainder <= r_aRaw;
              r_exp       <= 1'b1;
            end else begin
              r_quotient  <= w_qFinal;
              r_remainder <= w_rFinal;
              r_exp       <= 1'b0;
            end
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_acc <= w_qBit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], w_qBit};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign exp       = r_exp;
  assign ready     = r_ready;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider at WIDTH=32.
//   - A table of hand-derived vectors is run first.
//   - Multi-cycle corner cases follow: a start during RUN, back-to-back
//     operations, and a reset during RUN.
//   - Randomised operations are then compared with an arithmetic reference
//     model that uses 64-bit integer division.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  A_in;
  logic [W-1:0]  B_in;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          exp;
  logic          ready;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cycleCount = 0;
  int acceptCycle = 0;

  typedef struct {
    bit         sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit         e;
  } vec_t;

  vec_t vecs[15];

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .A_in      (A_in),
    .B_in      (B_in),
    .quotient  (quotient),
    .remainder (remainder),
    .exp       (exp),
    .ready     (ready),
    .busy      (busy)
  );

  // Free-running clock and an edge counter used to measure latency.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Records one comparison and reports it if it differs.
  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // Reference: plain 64-bit integer division, with the divide-by-zero rule.
  task automatic model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output bit e);
    longint sa, sb, sq, sr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      e = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      sq = sa / sb;
      sr = sa % sb;
      q = sq[31:0];
      r = sr[31:0];
      e = 1'b0;
    end
  endtask

  function automatic int expLat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIVIDER_EARLY_EXIT_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return W + 1;
  endfunction

  // Drives a request for one edge. It is called #1 after a rising edge and
  // returns #1 after the edge that sampled start.
  task automatic startOp(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    is_signed = sgn;
    A_in      = a;
    B_in      = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    acceptCycle = cycleCount;
    start = 1'b0;
  endtask

  // Waits, with a cycle budget, for ready and reports the latency in edges.
  task automatic awaitReady(output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #1;
      if (ready) begin
        ok  = 1'b1;
        lat = cycleCount - acceptCycle;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout: got=no ready expected=ready within 60 cycles");
    end
  endtask

  task automatic checkOutput(input logic [31:0] q, input logic [31:0] r, input bit e);
    checkVal("quotient", quotient, q);
    checkVal("remainder", remainder, r);
    checkVal("exp", {31'd0, exp}, {31'd0, e});
  endtask

  // Runs one complete operation and checks latency, handshake and results.
  task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] q, input logic [31:0] r, input bit e);
    int lat;
    bit ok;
    startOp(sgn, a, b);
    awaitReady(lat, ok);
    if (ok) begin
      checkVal("latency", lat, expLat(a, b));
      checkVal("busyAtReady", {31'd0, busy}, 32'd0);
      checkOutput(q, r, e);
    end
  endtask

  initial begin
    int lat;
    bit ok;
    bit sawReady;
    logic [31:0] ra, rb, mq, mr;
    bit me;
    bit rs;

    vecs[0]  = '{1'b1, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[4]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[5]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[6]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[8]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[9]  = '{1'b1, 32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF0,  1'b1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[12] = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5,          1'b0};
    vecs[13] = '{1'b1, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[14] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};

    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    A_in = '0;
    B_in = '0;

    // Reset state, with start asserted to show that reset wins.
    @(posedge clock);
    #1;
    start = 1'b1;
    A_in = 32'd9;
    B_in = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkVal("resetBusy", {31'd0, busy}, 32'd0);
    checkVal("resetReady", {31'd0, ready}, 32'd0);
    checkOutput(32'd0, 32'd0, 1'b0);
    reset = 1'b0;

    // Table-driven vectors, each followed by a check that ready is one cycle wide.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e);
      @(posedge clock);
      #1;
      checkVal("readyPulseWidth", {31'd0, ready}, 32'd0);
    end

    // A start during RUN with new operands must be ignored entirely.
    startOp(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clock);
    #1;
    checkVal("busyInRun", {31'd0, busy}, 32'd1);
    is_signed = 1'b1;
    A_in = 32'd999;
    B_in = 32'd3;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    awaitReady(lat, ok);
    if (ok) begin
      checkVal("midRunLatency", lat, W + 1);
      checkOutput(32'd14, 32'd2, 1'b0);
    end
    sawReady = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (ready) sawReady = 1'b1;
    end
    checkVal("midRunNoExtraReady", {31'd0, sawReady}, 32'd0);

    // Back-to-back: the second start is presented during the DONE cycle.
    startOp(1'b1, 32'd7, 32'd2);
    awaitReady(lat, ok);
    if (ok) checkOutput(32'd3, 32'd1, 1'b0);
    startOp(1'b1, 32'hFFFF_FFF9, 32'd2);
    awaitReady(lat, ok);
    if (ok) begin
      checkVal("backToBackLatency", lat, W + 1);
      checkOutput(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    end
    @(posedge clock);
    #1;

    // A reset 10 cycles into RUN aborts the operation with no ready pulse.
    startOp(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkVal("abortBusy", {31'd0, busy}, 32'd0);
    checkVal("abortReady", {31'd0, ready}, 32'd0);
    checkOutput(32'd0, 32'd0, 1'b0);
    sawReady = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (ready) sawReady = 1'b1;
    end
    checkVal("abortNoReady", {31'd0, sawReady}, 32'd0);
    applyStimulus(1'b1, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);

    // Randomised operations compared against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'd0 - $urandom_range(1, 15);
        default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      rs = 1'($urandom_range(0, 1));
      model(rs, ra, rb, mq, mr, me);
      applyStimulus(rs, ra, rb, mq, mr, me);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
